// File: rtl/nanorv32_pmux_pkg.sv
// Shared constants for the port A pin multiplexer: register map, SEL encodings
// and EVT field offsets.
package nanorv32_pmux_pkg;

    localparam logic [4:0] ADDR_SEL     = 5'h00;
    localparam logic [4:0] ADDR_FILT_EN = 5'h04;
    localparam logic [4:0] ADDR_IRQ_EN  = 5'h08;
    localparam logic [4:0] ADDR_EVT     = 5'h0C;
    localparam logic [4:0] ADDR_PIN     = 5'h10;

    localparam logic [1:0] PMUX_FUNC0 = 2'd0;
    localparam logic [1:0] PMUX_FUNC1 = 2'd1;
    localparam logic [1:0] PMUX_FUNC2 = 2'd2;
    localparam logic [1:0] PMUX_DIS   = 2'd3;

    localparam int EVT_RISE_OFS = 0;
    localparam int EVT_FALL_OFS = 16;

endpackage

// File: rtl/nanorv32_pmux_filt.sv
// One port A input pin: two-flop synchroniser, optional glitch filter and
// rise/fall pulses that line up with the edge on which filt changes.
module nanorv32_pmux_filt #(
    parameter int FILT_LEN = 8
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic pad_din,
    input  logic filt_en,
    output logic filt,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(FILT_LEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

    logic          sync1;
    logic          sync2;
    logic          filt_en_q;
    logic          filt_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    // A change of filt_en restarts the count and holds filt for that cycle.
    always_comb begin
        filt_next = filt;
        cnt_next  = '0;
        if (filt_en == filt_en_q) begin
            if (!filt_en) begin
                filt_next = sync2;
            end else if (sync2 != filt) begin
                if (cnt == CNT_LAST) begin
                    filt_next = sync2;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
        end
    end

    assign rise = ~filt & filt_next;
    assign fall = filt & ~filt_next;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            filt      <= 1'b0;
            cnt       <= '0;
            filt_en_q <= 1'b0;
        end else begin
            sync1     <= pad_din;
            sync2     <= sync1;
            filt      <= filt_next;
            cnt       <= cnt_next;
            filt_en_q <= filt_en;
        end
    end

endmodule

// File: rtl/nanorv32_pmux.sv
// Port A pin multiplexer: register file, per-pin function mux towards the pad
// ring, per-pin input filters, sticky edge events and the masked interrupt.
module nanorv32_pmux
    import nanorv32_pmux_pkg::*;
#(
    parameter int CHIP_PORT_A_WIDTH = 16,
    parameter int FILT_LEN          = 8
) (
    input  logic                           clk_in,
    input  logic                           rst_n,
    input  logic                           reg_sel,
    input  logic                           reg_wr,
    input  logic [4:0]                     reg_addr,
    input  logic [31:0]                    reg_wdata,
    output logic [31:0]                    reg_rdata,
    output logic                           reg_ready,
    input  logic [3*CHIP_PORT_A_WIDTH-1:0] func_dout,
    input  logic [3*CHIP_PORT_A_WIDTH-1:0] func_oe,
    output logic [CHIP_PORT_A_WIDTH-1:0]   pmux_func_din,
    output logic [CHIP_PORT_A_WIDTH-1:0]   pmux_pad_dout,
    output logic [CHIP_PORT_A_WIDTH-1:0]   pmux_pad_oe,
    output logic [CHIP_PORT_A_WIDTH-1:0]   pmux_pad_ie,
    input  logic [CHIP_PORT_A_WIDTH-1:0]   pad_pmux_din,
    output logic                           pmux_irq
);

    localparam int W = CHIP_PORT_A_WIDTH;

    logic [2*W-1:0] sel_q;
    logic [W-1:0]   filt_en_q;
    logic [W-1:0]   irq_en_q;
    logic [W-1:0]   evt_rise_q;
    logic [W-1:0]   evt_fall_q;
    logic [W-1:0]   filt;
    logic [W-1:0]   rise;
    logic [W-1:0]   fall;
    logic [W-1:0]   clr_rise;
    logic [W-1:0]   clr_fall;
    logic           access;
    logic           wr_en;
    logic           rd_en;
    logic [31:0]    rdata_next;

    // A strobe seen while ready is still high belongs to the finished access.
    assign access = reg_sel & ~reg_ready;
    assign wr_en  = access & reg_wr;
    assign rd_en  = access & ~reg_wr;

    assign clr_rise = (wr_en && reg_addr == ADDR_EVT) ? reg_wdata[EVT_RISE_OFS +: W] : '0;
    assign clr_fall = (wr_en && reg_addr == ADDR_EVT) ? reg_wdata[EVT_FALL_OFS +: W] : '0;

    always_comb begin
        rdata_next = '0;
        case (reg_addr)
            ADDR_SEL:     rdata_next[2*W-1:0] = sel_q;
            ADDR_FILT_EN: rdata_next[W-1:0]   = filt_en_q;
            ADDR_IRQ_EN:  rdata_next[W-1:0]   = irq_en_q;
            ADDR_EVT: begin
                rdata_next[EVT_RISE_OFS +: W] = evt_rise_q;
                rdata_next[EVT_FALL_OFS +: W] = evt_fall_q;
            end
            ADDR_PIN:     rdata_next[W-1:0]   = filt;
            default:      rdata_next          = '0;
        endcase
    end

    // New events are OR-ed in after the clear so a coincident set survives.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            sel_q      <= '0;
            filt_en_q  <= '0;
            irq_en_q   <= '0;
            evt_rise_q <= '0;
            evt_fall_q <= '0;
            reg_rdata  <= '0;
            reg_ready  <= 1'b0;
            pmux_irq   <= 1'b0;
        end else begin
            reg_ready <= access;
            if (rd_en) begin
                reg_rdata <= rdata_next;
            end
            if (wr_en) begin
                case (reg_addr)
                    ADDR_SEL:     sel_q     <= reg_wdata[2*W-1:0];
                    ADDR_FILT_EN: filt_en_q <= reg_wdata[W-1:0];
                    ADDR_IRQ_EN:  irq_en_q  <= reg_wdata[W-1:0];
                    default:      ;
                endcase
            end
            evt_rise_q <= (evt_rise_q & ~clr_rise) | rise;
            evt_fall_q <= (evt_fall_q & ~clr_fall) | fall;
            pmux_irq   <= |((evt_rise_q | evt_fall_q) & irq_en_q);
        end
    end

    for (genvar i = 0; i < W; i++) begin : g_pin
        logic [1:0] s;
        assign s = sel_q[2*i +: 2];

        assign pmux_pad_dout[i] = (s == PMUX_FUNC0) ? func_dout[i]     :
                                  (s == PMUX_FUNC1) ? func_dout[W+i]   :
                                  (s == PMUX_FUNC2) ? func_dout[2*W+i] : 1'b0;
        assign pmux_pad_oe[i]   = (s == PMUX_FUNC0) ? func_oe[i]       :
                                  (s == PMUX_FUNC1) ? func_oe[W+i]     :
                                  (s == PMUX_FUNC2) ? func_oe[2*W+i]   : 1'b0;
        assign pmux_pad_ie[i]   = (s != PMUX_DIS);

        nanorv32_pmux_filt #(
            .FILT_LEN (FILT_LEN)
        ) u_filt (
            .clk_in  (clk_in),
            .rst_n   (rst_n),
            .pad_din (pad_pmux_din[i]),
            .filt_en (filt_en_q[i]),
            .filt    (filt[i]),
            .rise    (rise[i]),
            .fall    (fall[i])
        );
    end

    assign pmux_func_din = filt;

endmodule
